// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM encoding, prescale limits,
// parity encoding and the configuration helpers used by the controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  localparam int MIN_PRESCALE   = 8;
  localparam int MAX_PRESCALE   = 32;
  localparam int MIN_DATA_WIDTH = 5;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic [3:0] clamp_data_length(input logic [3:0] len, input int max_width);
    if (int'(len) < MIN_DATA_WIDTH) return 4'(MIN_DATA_WIDTH);
    if (int'(len) > max_width) return 4'(max_width);
    return len;
  endfunction

  function automatic logic prescale_illegal(input int ps);
    return (ps % 2 != 0) || (ps < MIN_PRESCALE) || (ps > MAX_PRESCALE);
  endfunction

endpackage

// File: rtl/uart_rx_oversample_counter.sv
// Oversampling edge counter with a 3-sample majority vote taken around the
// middle of each bit period.
module uart_rx_oversample_counter #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      rx_i,
  output logic                      bit_done_o,
  output logic                      vote_o
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] count_q, count_d, half;
  logic [2:0]                samples_q, samples_d;

  assign half       = prescale_i >> 1;
  assign bit_done_o = (count_q == prescale_i - ONE);
  assign vote_o     = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                      (samples_q[1] & samples_q[2]);

  always_comb begin
    count_d   = count_q + ONE;
    samples_d = samples_q;
    if (clear_i || bit_done_o) count_d = '0;
    if (count_q == half - ONE) samples_d[0] = rx_i;
    if (count_q == half)       samples_d[1] = rx_i;
    if (count_q == half + ONE) samples_d[2] = rx_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q   <= '0;
      samples_q <= '0;
    end else begin
      count_q   <= count_d;
      samples_q <= samples_d;
    end
  end

endmodule

// File: rtl/uart_receiver_controller.sv
// UART receive controller: synchronizes the line, frames start/data/parity/stop
// bits and reports exactly one status pulse per completed frame.
module uart_receiver_controller
  import uart_rx_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [3:0]                data_length,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic                      stop_bits,
  input  logic                      serial_data_in,
  output logic [MAX_DATA_WIDTH-1:0] rx_data,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      break_detect,
  output logic                      busy,
  output logic                      config_error
);

  rx_state_e state_q, state_d;

  logic                      rx_meta_q, rx_s_q;
  logic                      wait_high_q;
  logic [3:0]                len_q, bit_cnt_q, last_bit;
  logic                      par_en_q, par_type_q, stop2_q, stop_cnt_q;
  logic                      par_acc_q, allzero_q, framing_q, perr_q;
  logic [MAX_DATA_WIDTH-1:0] shift_q, rx_data_q;
  logic                      cfg_bad, bit_done, vote, clear_cnt, start_entry, load_rx;

  assign cfg_bad     = prescale_illegal(int'(prescale));
  assign last_bit    = len_q - 4'd1;
  assign clear_cnt   = (state_d != state_q) || (state_q == IDLE) || (state_q == DONE);
  assign start_entry = (state_d == START) && (state_q != START);
  // The last stop vote is folded in here so rx_data is already valid alongside data_valid.
  assign load_rx     = (state_q == STOP) && (state_d == DONE) && vote &&
                       !framing_q && !perr_q && !(allzero_q & ~vote);

  uart_rx_oversample_counter #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_counter (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clear_i   (clear_cnt),
    .prescale_i(prescale),
    .rx_i      (rx_s_q),
    .bit_done_o(bit_done),
    .vote_o    (vote)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s_q && enable && !cfg_bad && !wait_high_q) state_d = START;
      START:   if (bit_done) state_d = vote ? IDLE : DATA;
      DATA:    if (bit_done && bit_cnt_q == last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done && stop_cnt_q == stop2_q) state_d = DONE;
      DONE:    state_d = (!allzero_q && !rx_s_q && enable && !cfg_bad) ? START : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && (!enable || cfg_bad)) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      wait_high_q <= 1'b0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      par_en_q    <= 1'b0;
      par_type_q  <= PARITY_EVEN;
      stop2_q     <= 1'b0;
      par_acc_q   <= 1'b0;
      allzero_q   <= 1'b0;
      framing_q   <= 1'b0;
      perr_q      <= 1'b0;
      shift_q     <= '0;
      rx_data_q   <= '0;
    end else begin
      rx_meta_q <= serial_data_in;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      // A break keeps the receiver parked until the line has been seen high again.
      if (state_q == DONE && allzero_q) wait_high_q <= 1'b1;
      else if (rx_s_q)                  wait_high_q <= 1'b0;
      if (start_entry) begin
        len_q      <= clamp_data_length(data_length, MAX_DATA_WIDTH);
        par_en_q   <= parity_enable;
        par_type_q <= parity_type;
        stop2_q    <= stop_bits;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        par_acc_q  <= 1'b0;
        allzero_q  <= 1'b1;
        framing_q  <= 1'b0;
        perr_q     <= 1'b0;
        shift_q    <= '0;
      end else if (bit_done) begin
        case (state_q)
          DATA: begin
            shift_q[bit_cnt_q] <= vote;
            bit_cnt_q          <= bit_cnt_q + 4'd1;
            par_acc_q          <= par_acc_q ^ vote;
            allzero_q          <= allzero_q & ~vote;
          end
          PARITY: begin
            perr_q    <= (par_acc_q ^ vote) != par_type_q;
            allzero_q <= allzero_q & ~vote;
          end
          STOP: begin
            framing_q  <= framing_q | ~vote;
            stop_cnt_q <= 1'b1;
            allzero_q  <= allzero_q & ~vote;
          end
          default: ;
        endcase
      end
      if (load_rx) rx_data_q <= shift_q;
    end
  end

  assign rx_data       = rx_data_q;
  assign busy          = (state_q != IDLE);
  assign config_error  = reset & cfg_bad;
  assign break_detect  = (state_q == DONE) && allzero_q;
  assign framing_error = (state_q == DONE) && !allzero_q && framing_q;
  assign parity_error  = (state_q == DONE) && !allzero_q && !framing_q && perr_q;
  assign data_valid    = (state_q == DONE) && !allzero_q && !framing_q && !perr_q;

endmodule

// File: tb/tb_uart_receiver_controller.sv
// Directed bench for uart_receiver_controller: drives whole serial frames and checks
// pulse counts, received words and busy/config behaviour against hand-computed values.
module tb_uart_receiver_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [3:0] data_length = 4'd8;
  logic       parity_enable = 1'b0;
  logic       parity_type = 1'b0;
  logic       stop_bits = 1'b0;
  logic       serial_data_in = 1'b1;
  logic [8:0] rx_data;
  logic       data_valid, parity_error, framing_error, break_detect, busy, config_error;

  int errors = 0;
  int checks = 0;
  int nDv = 0, nPe = 0, nFe = 0, nBd = 0, busyCycles = 0, busyRises = 0;
  logic busyPrev = 1'b0;
  logic [8:0] rxLog [0:15];

  always #5 clk = ~clk;

  uart_receiver_controller dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .prescale      (prescale),
    .data_length   (data_length),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .stop_bits     (stop_bits),
    .serial_data_in(serial_data_in),
    .rx_data       (rx_data),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .break_detect  (break_detect),
    .busy          (busy),
    .config_error  (config_error)
  );

  // Observe pulses and busy activity on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (data_valid) begin
      nDv = nDv + 1;
      rxLog[nDv % 16] = rx_data;
    end
    if (parity_error)  nPe = nPe + 1;
    if (framing_error) nFe = nFe + 1;
    if (break_detect)  nBd = nBd + 1;
    if (busy) busyCycles = busyCycles + 1;
    if (busy && !busyPrev) busyRises = busyRises + 1;
    busyPrev = busy;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic hold_line(input logic b, input int cycles);
    serial_data_in = b;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] data, input int nbits, input int ps, input bit pen,
                            input logic pbit, input int nstop, input logic lastStop);
    hold_line(1'b0, ps);
    for (int i = 0; i < nbits; i++) hold_line(data[i], ps);
    if (pen) hold_line(pbit, ps);
    hold_line(1'b1, ps);
    if (nstop == 2) hold_line(lastStop, ps);
    serial_data_in = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 9'h000) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 000", rx_data); end
    checks++; if ({data_valid, parity_error, framing_error, break_detect} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {data_valid, parity_error, framing_error, break_detect}); end
    checks++; if (config_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_config_error: got %b expected 0", config_error); end
    @(posedge clk); #1;
    reset = 1'b1;
    enable = 1'b1;
    hold_line(1'b1, 8);
  endtask

  task automatic test_8n1;
    int dv0, pe0, fe0, bd0, bc0;
    dv0 = nDv; pe0 = nPe; fe0 = nFe; bd0 = nBd; bc0 = busyCycles;
    send_frame(9'h0A5, 8, 8, 0, 1'b0, 1, 1'b1);
    hold_line(1'b1, 16);
    checks++; if (nDv - dv0 != 1) begin errors++; $display("[TB] FAIL 8n1_dv_count: got %0d expected 1", nDv - dv0); end
    checks++; if (rxLog[nDv % 16] !== 9'h0A5) begin errors++; $display("[TB] FAIL 8n1_rx_at_pulse: got %h expected 0a5", rxLog[nDv % 16]); end
    checks++; if (rx_data !== 9'h0A5) begin errors++; $display("[TB] FAIL 8n1_rx_data: got %h expected 0a5", rx_data); end
    checks++; if ((nPe - pe0) + (nFe - fe0) + (nBd - bd0) != 0) begin
      errors++; $display("[TB] FAIL 8n1_other_pulses: got %0d expected 0", (nPe - pe0) + (nFe - fe0) + (nBd - bd0)); end
    checks++; if (busyCycles - bc0 < 79 || busyCycles - bc0 > 81) begin
      errors++; $display("[TB] FAIL 8n1_busy_len: got %0d expected 80+-1", busyCycles - bc0); end
  endtask

  task automatic test_parity;
    int dv0, pe0, fe0;
    prescale = 6'd16; data_length = 4'd7; parity_enable = 1'b1; parity_type = 1'b1;
    dv0 = nDv; pe0 = nPe; fe0 = nFe;
    // 0x35 has four ones in seven bits, so odd parity needs a 1; send 0 instead.
    send_frame(9'h035, 7, 16, 1, 1'b0, 1, 1'b1);
    hold_line(1'b1, 32);
    checks++; if (nPe - pe0 != 1) begin errors++; $display("[TB] FAIL parity_pe_count: got %0d expected 1", nPe - pe0); end
    checks++; if (nDv - dv0 != 0) begin errors++; $display("[TB] FAIL parity_dv_count: got %0d expected 0", nDv - dv0); end
    checks++; if (nFe - fe0 != 0) begin errors++; $display("[TB] FAIL parity_fe_count: got %0d expected 0", nFe - fe0); end
    checks++; if (rx_data !== 9'h0A5) begin errors++; $display("[TB] FAIL parity_rx_held: got %h expected 0a5", rx_data); end
    send_frame(9'h035, 7, 16, 1, 1'b1, 1, 1'b1);
    hold_line(1'b1, 32);
    checks++; if (nDv - dv0 != 1) begin errors++; $display("[TB] FAIL parity_good_dv: got %0d expected 1", nDv - dv0); end
    checks++; if (rx_data !== 9'h035) begin errors++; $display("[TB] FAIL parity_good_rx: got %h expected 035", rx_data); end
  endtask

  task automatic test_glitch;
    int sum0, len;
    bit seen;
    data_length = 4'd8; parity_enable = 1'b0; parity_type = 1'b0;
    sum0 = nDv + nPe + nFe + nBd;
    hold_line(1'b0, 2);
    serial_data_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL glitch_start: got busy=0 expected busy=1 within 10 cycles"); end
    len = 0;
    while (busy && len < 40) begin
      len++;
      @(negedge clk);
    end
    checks++; if (len > 16) begin errors++; $display("[TB] FAIL glitch_idle_time: got %0d cycles expected <=16", len); end
    @(posedge clk); #1;
    hold_line(1'b1, 16);
    checks++; if (nDv + nPe + nFe + nBd != sum0) begin
      errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", nDv + nPe + nFe + nBd - sum0); end
  endtask

  task automatic test_break;
    int bd0, others0, rise0, dv0;
    prescale = 6'd8;
    bd0 = nBd; others0 = nDv + nPe + nFe; rise0 = busyRises;
    hold_line(1'b0, 96);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL break_busy_low: got %b expected 0", busy); end
    checks++; if (nBd - bd0 != 1) begin errors++; $display("[TB] FAIL break_count: got %0d expected 1", nBd - bd0); end
    checks++; if (nDv + nPe + nFe != others0) begin
      errors++; $display("[TB] FAIL break_other_pulses: got %0d expected 0", nDv + nPe + nFe - others0); end
    checks++; if (busyRises - rise0 != 1) begin errors++; $display("[TB] FAIL break_no_restart: got %0d frames expected 1", busyRises - rise0); end
    @(posedge clk); #1;
    hold_line(1'b1, 16);
    dv0 = nDv;
    send_frame(9'h03C, 8, 8, 0, 1'b0, 1, 1'b1);
    hold_line(1'b1, 16);
    checks++; if (nDv - dv0 != 1) begin errors++; $display("[TB] FAIL break_recover_dv: got %0d expected 1", nDv - dv0); end
    checks++; if (rx_data !== 9'h03C) begin errors++; $display("[TB] FAIL break_recover_rx: got %h expected 03c", rx_data); end
  endtask

  task automatic test_framing;
    int fe0, dv0, bd0;
    prescale = 6'd16; stop_bits = 1'b1;
    fe0 = nFe; dv0 = nDv; bd0 = nBd;
    send_frame(9'h055, 8, 16, 0, 1'b0, 2, 1'b0);
    hold_line(1'b1, 32);
    checks++; if (nFe - fe0 != 1) begin errors++; $display("[TB] FAIL framing_count: got %0d expected 1", nFe - fe0); end
    checks++; if (nDv - dv0 != 0) begin errors++; $display("[TB] FAIL framing_dv: got %0d expected 0", nDv - dv0); end
    checks++; if (nBd - bd0 != 0) begin errors++; $display("[TB] FAIL framing_bd: got %0d expected 0", nBd - bd0); end
    checks++; if (rx_data !== 9'h03C) begin errors++; $display("[TB] FAIL framing_rx_held: got %h expected 03c", rx_data); end
  endtask

  task automatic test_back_to_back;
    int dv0;
    stop_bits = 1'b0;
    dv0 = nDv;
    send_frame(9'h001, 8, 16, 0, 1'b0, 1, 1'b1);
    send_frame(9'h0FF, 8, 16, 0, 1'b0, 1, 1'b1);
    hold_line(1'b1, 32);
    checks++; if (nDv - dv0 != 2) begin errors++; $display("[TB] FAIL b2b_dv_count: got %0d expected 2", nDv - dv0); end
    checks++; if (rxLog[(dv0 + 1) % 16] !== 9'h001) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 001", rxLog[(dv0 + 1) % 16]); end
    checks++; if (rxLog[(dv0 + 2) % 16] !== 9'h0FF) begin errors++; $display("[TB] FAIL b2b_second: got %h expected 0ff", rxLog[(dv0 + 2) % 16]); end
    checks++; if (rx_data !== 9'h0FF) begin errors++; $display("[TB] FAIL b2b_rx_data: got %h expected 0ff", rx_data); end
  endtask

  task automatic test_enable_abort;
    int sum0;
    sum0 = nDv + nPe + nFe + nBd;
    hold_line(1'b0, 16);
    hold_line(1'b0, 40);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    hold_line(1'b1, 200);
    checks++; if (nDv + nPe + nFe + nBd != sum0) begin
      errors++; $display("[TB] FAIL abort_pulses: got %0d expected 0", nDv + nPe + nFe + nBd - sum0); end
    enable = 1'b1;
    hold_line(1'b1, 8);
  endtask

  task automatic test_reset_mid_frame;
    int sum0;
    sum0 = nDv + nPe + nFe + nBd;
    hold_line(1'b0, 16);
    hold_line(1'b1, 40);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 9'h000) begin errors++; $display("[TB] FAIL rstmid_rx_data: got %h expected 000", rx_data); end
    checks++; if ({data_valid, parity_error, framing_error, break_detect, config_error} !== 5'b00000) begin
      errors++; $display("[TB] FAIL rstmid_outputs: got %b expected 00000", {data_valid, parity_error, framing_error, break_detect, config_error}); end
    @(posedge clk); #1;
    reset = 1'b1;
    hold_line(1'b1, 200);
    checks++; if (nDv + nPe + nFe + nBd != sum0) begin
      errors++; $display("[TB] FAIL rstmid_pulses: got %0d expected 0", nDv + nPe + nFe + nBd - sum0); end
  endtask

  task automatic test_config;
    int rise0;
    prescale = 6'd7;
    @(negedge clk);
    checks++; if (config_error !== 1'b1) begin errors++; $display("[TB] FAIL cfg_odd: got %b expected 1", config_error); end
    rise0 = busyRises;
    @(posedge clk); #1;
    hold_line(1'b0, 40);
    checks++; if (busyRises != rise0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL cfg_ignore_start: got %0d frames busy=%b expected 0 frames busy=0", busyRises - rise0, busy); end
    hold_line(1'b1, 8);
    prescale = 6'd34;
    @(negedge clk);
    checks++; if (config_error !== 1'b1) begin errors++; $display("[TB] FAIL cfg_too_big: got %b expected 1", config_error); end
    prescale = 6'd6;
    @(negedge clk);
    checks++; if (config_error !== 1'b1) begin errors++; $display("[TB] FAIL cfg_too_small: got %b expected 1", config_error); end
    prescale = 6'd32;
    @(negedge clk);
    checks++; if (config_error !== 1'b0) begin errors++; $display("[TB] FAIL cfg_max_legal: got %b expected 0", config_error); end
    prescale = 6'd8;
    @(negedge clk);
    checks++; if (config_error !== 1'b0) begin errors++; $display("[TB] FAIL cfg_min_legal: got %b expected 0", config_error); end
  endtask

  initial begin
    $display("[TB] starting uart_receiver_controller bench");
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_framing();
    test_back_to_back();
    test_enable_abort();
    test_reset_mid_frame();
    test_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver_controller.md
UART_RECEIVER_CONTROLLER -- requirements
Module: uart_receiver_controller

Interface
REQ-001 SHALL have parameter MAX_DATA_WIDTH, default 9, meaning the widest data field supported; legal range 5..9.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 6, meaning the width of the oversampling ratio input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for the whole block.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: receiver enable.
REQ-006 SHALL have port prescale, input, PRESCALE_WIDTH bits: oversampling ratio; legal values are even, 8..32.
REQ-007 SHALL have port data_length, input, 4 bits: data bits per frame.
REQ-008 SHALL have port parity_enable, input, 1 bit.
REQ-009 SHALL have port parity_type, input, 1 bit: 0 = even, 1 = odd.
REQ-010 SHALL have port stop_bits, input, 1 bit: 0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port serial_data_in, input, 1 bit: asynchronous line input, idle high.
REQ-012 SHALL have port rx_data, output, MAX_DATA_WIDTH bits: received word, LSB-aligned.
REQ-013 SHALL have ports data_valid, parity_error, framing_error and break_detect, outputs, 1 bit each: one-cycle pulses.
REQ-014 SHALL have port busy, output, 1 bit: high while the FSM is in any state other than IDLE.
REQ-015 SHALL have port config_error, output, 1 bit: level, high while prescale is illegal.

Function
REQ-016 SHALL pass serial_data_in through a 2-flop synchronizer; all line decisions use the synchronized value rx_s.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-018 SHALL run an edge counter 0..prescale-1 in every state except IDLE and DONE, cleared on each state entry; a bit period completes when the count reaches prescale-1.
REQ-019 SHALL sample each bit by 3-sample majority vote at edges prescale/2-1, prescale/2 and prescale/2+1.
REQ-020 SHALL move IDLE->START when rx_s=0, enable=1 and config_error=0.
REQ-021 SHALL latch data_length, parity_enable, parity_type and stop_bits on START entry; input changes mid-frame have no effect.
REQ-022 SHALL clamp a latched data_length below 5 to 5 and above MAX_DATA_WIDTH to MAX_DATA_WIDTH.
REQ-023 SHALL treat a START majority vote of 1 as a glitch: return to IDLE with no pulse asserted.
REQ-024 SHALL shift DATA bits in LSB-first, using a bit counter from 0 to N-1; after bit N-1 it goes to PARITY if parity is enabled, else to STOP.
REQ-025 SHALL set parity mismatch when the XOR of the data bits and the parity bit is not equal to parity_type, then continue to STOP.
REQ-026 SHALL check one or two stop bits; any stop sample of 0 sets framing fault; after the last stop bit the FSM goes to DONE.
REQ-027 SHALL spend exactly one cycle in DONE, asserting exactly one of the following in priority order:
- break_detect, if all data, parity and stop samples were 0;
- framing_error, on a framing fault;
- parity_error, on a parity mismatch;
- data_valid, otherwise.
REQ-028 SHALL update rx_data only in the DONE cycle that asserts data_valid, with bits N and above zero; rx_data holds its value otherwise.
REQ-029 SHALL, on break, stay in IDLE without re-entering START until rx_s has been 1 for at least one cycle.
REQ-030 SHALL move DONE->START directly when rx_s=0 (back-to-back frames), else DONE->IDLE.
REQ-031 SHALL abort to IDLE on the next clock when enable=0 mid-frame, with no pulse.
REQ-032 SHALL assert config_error when prescale is odd, <8 or >32; an illegal prescale holds the block in IDLE.

Reset
REQ-033 SHALL, when reset=0 at a clk edge, put the FSM in IDLE, clear all counters, set the synchronizer flops to 1, and drive every output to 0 (rx_data=0).
REQ-034 SHALL treat reset mid-frame as discarding the frame with no pulse emitted.

Structure
REQ-035 SHALL place the following in shared package uart_rx_pkg: the state encoding (3 bits), MIN_PRESCALE=8, MAX_PRESCALE=32, and the PARITY_EVEN/PARITY_ODD constants.
REQ-036 SHALL implement the edge counter and majority sampler as the sub-module uart_rx_oversample_counter.

Verification
REQ-037 SHALL cover: prescale=8, 8N1, byte 0xA5 -> data_valid pulse, rx_data=0xA5, busy high for 80 cycles (±1).
REQ-038 SHALL cover: prescale=16, 7 data bits, odd parity, 0x35 sent with wrong parity bit -> parity_error pulse only, rx_data unchanged.
REQ-039 SHALL cover: prescale=16, 2-cycle low glitch -> return to IDLE within 16 cycles, no pulses.
REQ-040 SHALL cover: 8N1, line low for 12 bit times -> one break_detect pulse, no restart until the line returns high.
REQ-041 SHALL cover: stop_bits=1, second stop bit 0 -> framing_error pulse; then back-to-back frames 0x01,0xFF -> two data_valid pulses.
REQ-042 SHALL cover: reset=0 mid-DATA -> next cycle busy=0 and all outputs 0; prescale=7 -> config_error=1 and a falling edge is ignored.
